// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the MEM-stage byte/halfword access sequencer.
package mem_seq_pkg;

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} mseq_state_t;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/mem_access_sequencer.sv
// MEM-stage controller: splits byte/halfword loads and stores into little-endian byte accesses.
// Optional ALIGN_CHECK_EN rejects odd-address halfwords with a misalign pulse instead of accessing memory.
module mem_access_sequencer #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_write,
    input  logic          req_half,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          misalign,
    output logic [AW-1:0] mem_address,
    output logic [7:0]    mem_write_data,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [7:0]    mem_read_data
);
    import mem_seq_pkg::*;

    mseq_state_t       state_reg;
    logic              write_reg;
    logic              half_reg;
    logic              signed_reg;
    logic [AW-1:0]     addr_reg;
    logic [BYTE_W-1:0] wdata_hi_reg;
    logic [BYTE_W-1:0] lo_reg;
    logic [DW-1:0]     rdata_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [AW-1:0]     mem_address_reg;
    logic [BYTE_W-1:0] mem_wdata_reg;
    logic              mem_read_reg;
    logic              mem_write_reg;
`ifdef ALIGN_CHECK_EN
    logic              misalign_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            write_reg       <= 1'b0;
            half_reg        <= 1'b0;
            signed_reg      <= 1'b0;
            addr_reg        <= '0;
            wdata_hi_reg    <= '0;
            lo_reg          <= '0;
            rdata_reg       <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            mem_address_reg <= '0;
            mem_wdata_reg   <= '0;
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
`ifdef ALIGN_CHECK_EN
            misalign_reg    <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
`ifdef ALIGN_CHECK_EN
            misalign_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg    <= req_write;
                        half_reg     <= req_half;
                        signed_reg   <= req_signed;
                        addr_reg     <= req_addr;
                        wdata_hi_reg <= req_wdata[2*BYTE_W-1:BYTE_W];
                        busy_reg     <= 1'b1;
`ifdef ALIGN_CHECK_EN
                        if (req_half && req_addr[0]) begin
                            state_reg    <= RESP;
                            done_reg     <= 1'b1;
                            misalign_reg <= 1'b1;
                        end else
`endif
                        begin
                            state_reg       <= LO;
                            mem_address_reg <= req_addr;
                            mem_wdata_reg   <= req_wdata[BYTE_W-1:0];
                            mem_read_reg    <= ~req_write;
                            mem_write_reg   <= req_write;
                        end
                    end
                end
                LO: begin
                    if (half_reg) begin
                        state_reg       <= HI;
                        mem_address_reg <= addr_reg + AW'(1);
                        mem_wdata_reg   <= wdata_hi_reg;
                        if (!write_reg)
                            lo_reg <= mem_read_data;
                    end else begin
                        state_reg     <= RESP;
                        done_reg      <= 1'b1;
                        mem_read_reg  <= 1'b0;
                        mem_write_reg <= 1'b0;
                        if (!write_reg) begin
                            if (signed_reg)
                                rdata_reg <= {{(DW-BYTE_W){mem_read_data[BYTE_W-1]}}, mem_read_data};
                            else
                                rdata_reg <= {{(DW-BYTE_W){1'b0}}, mem_read_data};
                        end
                    end
                end
                HI: begin
                    state_reg     <= RESP;
                    done_reg      <= 1'b1;
                    mem_read_reg  <= 1'b0;
                    mem_write_reg <= 1'b0;
                    if (!write_reg)
                        rdata_reg <= {mem_read_data, lo_reg};
                end
                RESP: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Strobes are masked by rst so an abort suppresses the access in the same cycle.
    assign mem_read       = mem_read_reg & ~rst;
    assign mem_write      = mem_write_reg & ~rst;
    assign mem_address    = mem_address_reg;
    assign mem_write_data = mem_wdata_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign rdata          = rdata_reg;
`ifdef ALIGN_CHECK_EN
    assign misalign       = misalign_reg;
`else
    assign misalign       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer with a behavioural 256x8 DataMemory.
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_half, req_signed;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        busy, done, misalign;
    logic [15:0] rdata;
    logic [7:0]  mem_address, mem_write_data, mem_read_data;
    logic        mem_read, mem_write;

    logic [7:0]  ram [0:255];

    always #5 clk = ~clk;

    mem_access_sequencer #(.AW(8), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_half(req_half),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .rdata(rdata), .misalign(misalign),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
    );

    always @(posedge clk) if (mem_write) ram[mem_address] <= mem_write_data;
    assign mem_read_data = ram[mem_address];

    typedef struct {
        logic [15:0] rdata;
        int          lat;
        logic        mis;
        int          start;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int checks = 0, errors = 0;
    int cyc = 0, busy_cnt = 0, done_cnt = 0, both_cnt = 0, wr_cnt = 0, issued = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_read && mem_write) both_cnt++;
        if (mem_write) wr_cnt++;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_rdata"}, rdata, e.rdata);
                check({e.tag, "_latency"}, cyc - e.start, e.lat);
                check({e.tag, "_misalign"}, misalign, e.mis);
                check({e.tag, "_busy_cycles"}, busy_cnt, e.lat);
                $display("txn %s rdata=%h latency=%0d misalign=%b busy_cycles=%0d",
                         e.tag, rdata, cyc - e.start, misalign, busy_cnt);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transaction retires.
    task automatic issue(input string tag, input bit wr, input bit half, input bit sgn,
                         input logic [7:0] addr, input logic [15:0] wd,
                         input logic [15:0] exp_rd, input int lat, input bit mis,
                         input bit hold_valid, input logic [7:0] alt_addr);
        exp_t x;
        int n;
        n = 0;
        while (busy && n < 50) begin @(posedge clk); #1; n++; end
        if (busy) check({tag, "_idle_timeout"}, 1, 0);
        req_write = wr; req_half = half; req_signed = sgn;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        x.rdata = exp_rd; x.lat = lat; x.mis = mis; x.start = cyc; x.tag = tag;
        sb.push_back(x);
        busy_cnt = 0;
        issued++;
        @(posedge clk); #1;
        if (hold_valid) req_addr = alt_addr;
        else req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
        req_valid = 1'b0;
        if (sb.size() != 0) begin
            check({tag, "_done_timeout"}, sb.size(), 0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    logic [7:0] save255, save0;
    int wr0, d0;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
        ram[102] = 8'h80; ram[103] = 8'h0A; ram[41] = 8'h77;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_half = 1'b0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_misalign", misalign, 0);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_mem_ctl", {mem_read, mem_write}, 2'b00);
        check("rst_mem_addr", mem_address, 8'h00);
        check("rst_mem_wdata", mem_write_data, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        issue("hload102", 0, 1, 0, 8'd102, 16'h0, 16'h0A80, 3, 0, 0, 8'd0);
        issue("bload102_s", 0, 0, 1, 8'd102, 16'h0, 16'hFF80, 2, 0, 0, 8'd0);
        issue("bload102_u", 0, 0, 0, 8'd102, 16'h0, 16'h0080, 2, 0, 0, 8'd0);
        issue("bload103_s", 0, 0, 1, 8'd103, 16'h0, 16'h000A, 2, 0, 0, 8'd0);

        issue("hstore200", 1, 1, 0, 8'd200, 16'hBEEF, 16'h000A, 3, 0, 0, 8'd0);
        check("ram200", ram[200], 8'hEF);
        check("ram201", ram[201], 8'hBE);

        save255 = ram[255]; save0 = ram[0]; wr0 = wr_cnt;
`ifdef ALIGN_CHECK_EN
        issue("hstore255", 1, 1, 0, 8'd255, 16'h1234, 16'h000A, 1, 1, 0, 8'd0);
        check("hstore255_no_write", wr_cnt - wr0, 0);
        check("ram255_kept", ram[255], save255);
        check("ram0_kept", ram[0], save0);
`else
        issue("hstore255", 1, 1, 0, 8'd255, 16'h1234, 16'h000A, 3, 0, 0, 8'd0);
        check("hstore255_writes", wr_cnt - wr0, 2);
        check("ram255", ram[255], 8'h34);
        check("ram0_wrap", ram[0], 8'h12);
`endif

        // Abort a halfword store while its high byte is on the bus.
        req_write = 1'b1; req_half = 1'b1; req_signed = 1'b0;
        req_addr = 8'd40; req_wdata = 16'hA55A; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_lo_addr", mem_address, 8'd40);
        check("abort_lo_write", mem_write, 1);
        @(posedge clk); #1;
        check("abort_hi_addr", mem_address, 8'd41);
        check("abort_hi_wdata", mem_write_data, 8'hA5);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rdata", rdata, 16'h0000);
        #1;
        rst = 1'b0;
        check("abort_ram40", ram[40], 8'h5A);
        check("abort_ram41", ram[41], 8'h77);
        @(posedge clk); #1;

        d0 = done_cnt;
        issue("hold_valid", 0, 0, 0, 8'd102, 16'h0, 16'h0080, 2, 0, 1, 8'd200);
        repeat (5) @(posedge clk);
        #1;
        check("hold_one_done", done_cnt - d0, 1);
        check("hold_idle", busy, 0);

        check("never_rd_and_wr", both_cnt, 0);
        check("sb_empty", sb.size(), 0);
        check("done_total", done_cnt, issued);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
